// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
// Shares one slot-driven UART master link between NUM_REQ requesters.
// Each transaction is one grant, one armed slot, one active slot and a
// single response cycle back to the winning requester.
//
// Optional feature: define UART_SCHED_STAT_EN to build per-requester
// saturating 8-bit frame-error counters on err_cnt. Without it, err_cnt
// is tied to zero and no counter registers exist.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   sched_en          allows new grants (never stops a running transaction)
//   t128ms_tick       one-cycle slot tick shared with the UART master
//   req, req_data     per-requester level request and flattened payloads
//   ack               one-cycle grant pulse (payload sampled this cycle)
//   rsp_valid         one-cycle response pulse to the granted requester
//   rsp_data, rsp_err response payload and frame-error flag
//   um_send_enable    master send_enable
//   um_par_data_in    master par_data_in
//   um_par_data_out   master par_data_out
//   um_error_flag     master error_flag
//   busy              high whenever the scheduler is not idle
//   err_cnt           per-requester error counters, 8 bits each
//   state_dbg         current FSM state encoding, for observation only
//
// Handshake: a requester holds req high with its payload stable. The
// cycle ack[i] is high is the cycle the payload is captured; after that,
// req/req_data may change freely. The result arrives later as a single
// rsp_valid[i] cycle with rsp_data/rsp_err valid only in that cycle.
// If req is still high afterwards it is a fresh request.
module uart_frame_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int NBIT    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sched_en,
  input  logic                    t128ms_tick,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*NBIT-1:0] req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [NBIT-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic                    um_send_enable,
  output logic [NBIT-1:0]         um_par_data_in,
  input  logic [NBIT-1:0]         um_par_data_out,
  input  logic                    um_error_flag,
  output logic                    busy,
  output logic [NUM_REQ*8-1:0]    err_cnt,
  output logic [1:0]              state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_ACTIVE  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;     // first index searched on the next grant
  logic [IW-1:0]   win_idx;    // requester owning the current transaction
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [NBIT-1:0] pick_data;
  logic            grant;
  logic            err_latch;
  logic            err_flag_d;
  logic            err_rise;

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int j;
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) pick_data = req_data[i*NBIT +: NBIT];
    end
  end

  assign grant    = !rst && (state == S_IDLE) && sched_en && pick_vld;
  assign err_rise = um_error_flag && !err_flag_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      win_idx        <= '0;
      um_par_data_in <= '0;
      err_latch      <= 1'b0;
      err_flag_d     <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_flag_d <= um_error_flag;
      if (grant) begin
        win_idx        <= pick_idx;
        um_par_data_in <= pick_data;
        rr_ptr         <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      // The closing tick cycle is still ACTIVE, so a rise on it is kept.
      if (state == S_CAPTURE) err_latch <= 1'b0;
      else if (state == S_ACTIVE && err_rise) err_latch <= 1'b1;
    end
  end

  // Next state and outputs. A tick seen while IDLE is ignored because the
  // ARM state is only entered on the following cycle.
  always_comb begin
    state_nxt      = state;
    ack            = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    um_send_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant) begin
          ack[pick_idx] = 1'b1;
          state_nxt     = S_ARM;
        end
      end
      S_ARM: begin
        um_send_enable = !rst;
        if (t128ms_tick) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (t128ms_tick) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A reset landing on this cycle aborts the response.
        if (!rst) begin
          rsp_valid[win_idx] = 1'b1;
          rsp_data           = um_par_data_out;
          rsp_err            = err_latch;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

`ifdef UART_SCHED_STAT_EN
  logic [7:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state == S_CAPTURE && err_latch && cnt_q[win_idx] != 8'hFF) begin
      cnt_q[win_idx] <= cnt_q[win_idx] + 8'd1;
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) err_cnt[i*8 +: 8] = cnt_q[i];
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_frame_scheduler.sv
module tb_uart_frame_scheduler;
  localparam int N = 4;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst, sched_en, t128ms_tick, um_error_flag;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   um_par_data_out;
  logic [N-1:0]   ack, rsp_valid;
  logic [W-1:0]   rsp_data, um_par_data_in;
  logic           rsp_err, um_send_enable, busy;
  logic [N*8-1:0] err_cnt;
  logic [1:0]     state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;     // model: first index searched on next grant
  int exp_cnt[N];      // model: per-requester error count

  always #5 clk = ~clk;

  uart_frame_scheduler #(.NUM_REQ(N), .NBIT(W)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .t128ms_tick(t128ms_tick),
    .req(req), .req_data(req_data), .ack(ack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .um_send_enable(um_send_enable),
    .um_par_data_in(um_par_data_in), .um_par_data_out(um_par_data_out),
    .um_error_flag(um_error_flag), .busy(busy), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Inputs change 2 units after the rising edge; checks happen 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Priority rule: search upward from start, wrapping; -1 if nobody asks.
  function automatic int rr_pick(logic [N-1:0] r, int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N*8-1:0] exp_err_cnt();
    logic [N*8-1:0] v;
    v = '0;
`ifdef UART_SCHED_STAT_EN
    for (int i = 0; i < N; i++) v[i*8 +: 8] = exp_cnt[i][7:0];
`endif
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; sched_en = 1'b0; t128ms_tick = 1'b0; um_error_flag = 1'b0;
    req = '0; req_data = '0; um_par_data_out = '0;
    cyc();
    cyc();
    rst = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
  endtask

  // One full transaction starting in an IDLE cycle; returns the winner.
  task automatic run_txn(input logic [N-1:0] r, input logic use_pin,
                         input logic [W-1:0] pin, input logic [W-1:0] pout,
                         input logic err, input logic tick_at_grant,
                         input logic drop_req, output int won);
    int w, a_gap, b_gap, e_pos;
    logic [N*W-1:0] rd;
    logic [W-1:0] wd;
    logic [N-1:0] exp_oh;
    for (int i = 0; i < N; i++) rd[i*W +: W] = W'($urandom);
    w = rr_pick(r, exp_ptr);
    if (use_pin) rd[w*W +: W] = pin;
    wd = rd[w*W +: W];
    exp_oh = N'(1) << w;
    won = w;

    sched_en = 1'b1; req = r; req_data = rd; t128ms_tick = tick_at_grant;
    um_error_flag = 1'b0;
    #1;
    checks++;
    if (ack !== exp_oh) begin errors++; $display("FAIL grant_ack: got %b exp %b", ack, exp_oh); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL grant_busy: got %b exp 0", busy); end
    exp_ptr = (w + 1) % N;

    // ARM: payload held even if the requester moves on.
    cyc();
    t128ms_tick = 1'b0;
    if (drop_req) req = '0;
    sched_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    #1;
    checks++;
    if (um_par_data_in !== wd) begin errors++; $display("FAIL par_data_in: got %h exp %h", um_par_data_in, wd); end
    checks++;
    if (um_send_enable !== 1'b1 || busy !== 1'b1 || ack !== '0) begin
      errors++;
      $display("FAIL arm_entry: send_en %b busy %b ack %b exp 1 1 0000", um_send_enable, busy, ack);
    end
    a_gap = $urandom_range(0, 4);
    for (int c = 0; c < a_gap; c++) begin
      cyc();
      #1;
      checks++;
      if (um_send_enable !== 1'b1) begin errors++; $display("FAIL arm_wait_send_en: got %b exp 1", um_send_enable); end
    end
    cyc();
    t128ms_tick = 1'b1;
    #1;
    checks++;
    if (um_send_enable !== 1'b1) begin errors++; $display("FAIL launch_send_en: got %b exp 1", um_send_enable); end

    // ACTIVE: one slot; error flag may rise anywhere including the tick cycle.
    cyc();
    b_gap = $urandom_range(0, 4);
    e_pos = $urandom_range(0, b_gap);
    for (int c = 0; c <= b_gap; c++) begin
      if (c > 0) cyc();
      t128ms_tick = (c == b_gap);
      um_par_data_out = (c == b_gap) ? pout : W'($urandom);
      if (err && c == e_pos) um_error_flag = 1'b1;
      #1;
      checks++;
      if (um_send_enable !== 1'b0 || rsp_valid !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL active: send_en %b rsp_valid %b busy %b exp 0 0000 1", um_send_enable, rsp_valid, busy);
      end
    end

    // CAPTURE
    cyc();
    t128ms_tick = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== exp_oh) begin errors++; $display("FAIL rsp_valid: got %b exp %b", rsp_valid, exp_oh); end
    checks++;
    if (rsp_data !== pout) begin errors++; $display("FAIL rsp_data: got %h exp %h", rsp_data, pout); end
    checks++;
    if (rsp_err !== err) begin errors++; $display("FAIL rsp_err: got %b exp %b", rsp_err, err); end
    checks++;
    if (ack !== '0) begin errors++; $display("FAIL capture_ack: got %b exp 0000", ack); end
    if (err && exp_cnt[w] < 255) exp_cnt[w]++;
    um_error_flag = 1'b0;

    cyc();
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: rsp_valid %b busy %b exp 0000 0", rsp_valid, busy);
    end
    checks++;
    if (err_cnt !== exp_err_cnt()) begin errors++; $display("FAIL err_cnt: got %h exp %h", err_cnt, exp_err_cnt()); end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; sched_en = 1'b1; req = '1;
    #1;
    checks++;
    if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    cyc();
    rst = 1'b0; sched_en = 1'b0; req = '0;
    #1;
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 || um_send_enable !== 1'b0 ||
        um_par_data_in !== '0 || busy !== 1'b0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rv %b rd %h re %b se %b pdi %h busy %b cnt %h exp all zero",
               rsp_valid, rsp_data, rsp_err, um_send_enable, um_par_data_in, busy, err_cnt);
    end
  endtask

  task automatic test_basic();
    int won;
    do_reset();
    run_txn(4'b0001, 1'b1, 10'h2A5, 10'h13C, 1'b0, 1'b0, 1'b0, won);
  endtask

  task automatic test_back_to_back();
    int won;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, 1'b0, '0, W'($urandom), 1'b0, 1'b0, 1'b0, won);
      checks++;
      if (won !== order[t]) begin errors++; $display("FAIL rr_order[%0d]: got %0d exp %0d", t, won, order[t]); end
    end
  endtask

  task automatic test_error();
    int won;
    do_reset();
    run_txn(4'b0100, 1'b0, '0, W'($urandom), 1'b1, 1'b0, 1'b1, won);
`ifdef UART_SCHED_STAT_EN
    checks++;
    if (err_cnt[23:16] !== 8'd1) begin errors++; $display("FAIL err_cnt_req2: got %0d exp 1", err_cnt[23:16]); end
`endif
  endtask

  task automatic test_reset_mid();
    int won;
    do_reset();
    sched_en = 1'b1; req = 4'b1110; req_data = '1;
    cyc();                                   // granted, now ARM
    req = '0;
    cyc(); t128ms_tick = 1'b1;               // launch
    cyc(); t128ms_tick = 1'b0;               // ACTIVE
    cyc(); rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== '0) begin errors++; $display("FAIL rst_mid_rsp: got %b exp 0000", rsp_valid); end
    cyc(); rst = 1'b0; t128ms_tick = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || um_send_enable !== 1'b0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL rst_mid_after: busy %b send_en %b rsp_valid %b exp 0 0 0000", busy, um_send_enable, rsp_valid);
    end
    cyc(); t128ms_tick = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    run_txn(4'b1111, 1'b0, '0, W'($urandom), 1'b0, 1'b0, 1'b0, won);
    checks++;
    if (won !== 0) begin errors++; $display("FAIL rst_mid_next_winner: got %0d exp 0", won); end
  endtask

  task automatic test_sched_en();
    int won;
    sched_en = 1'b0; req = 4'b0010; req_data = '0;
    for (int s = 0; s < 5; s++) begin
      int gap;
      gap = $urandom_range(2, 5);
      for (int c = 0; c <= gap; c++) begin
        cyc();
        t128ms_tick = (c == gap);
        #1;
        checks++;
        if (ack !== '0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL sched_off: ack %b busy %b exp 0000 0", ack, busy);
        end
      end
    end
    cyc(); t128ms_tick = 1'b0;
    run_txn(4'b0010, 1'b0, '0, W'($urandom), 1'b0, 1'b0, 1'b0, won);
  endtask

  task automatic test_tick_at_grant();
    int won;
    run_txn(4'b1000, 1'b0, '0, W'($urandom), 1'b0, 1'b1, 1'b0, won);
  endtask

  task automatic test_random();
    int won;
    logic [N-1:0] r;
    for (int t = 0; t < 20; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      run_txn(r, 1'b0, '0, W'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), won);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_sched_en();
    test_tick_at_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
